mem_arbiter_fsm: RTL and testbench
==================================

Name: mem_arbiter_fsm

Overview:
Sequenced arbiter that shares the single main-memory port between ICACHE (read-only) and DCACHE (read/write). Requests are latched, and round-robin arbitration applies when both caches are pending. Each transaction runs one at a time through an ISSUE/WAIT/DONE state machine, with a timeout on a stuck memory. It sits between the two cache controllers and the memory interface, and drives memory only from registered state, with no combinational path from requester inputs.

Parameters:
TIMEOUT, 1023, maximum WAIT-state cycles before a transaction is aborted; 0 disables the timeout
TO_W, 10, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
icache_addr  input  32  ICACHE read address
icache_req  input  1  ICACHE read request, held until icache_ready
icache_rdata  output  32  read data, valid while icache_ready=1
icache_ready  output  1  one-cycle completion pulse to ICACHE
dcache_addr  input  32  DCACHE address
dcache_wdata  input  32  DCACHE write data
dcache_wmask  input  4  DCACHE byte-enable mask
dcache_wen  input  1  DCACHE write request, held until dcache_ready
dcache_ren  input  1  DCACHE read request, held until dcache_ready
dcache_rdata  output  32  read data, valid while dcache_ready=1
dcache_ready  output  1  one-cycle completion pulse to DCACHE
mem_addr  output  32  memory address, latched per transaction
mem_wdata  output  32  memory write data, latched
mem_wmask  output  4  write strobe, nonzero for exactly one cycle per write
mem_rstrb  output  1  read strobe, one-cycle pulse
mem_rdata  input  32  memory read data
mem_rbusy  input  1  memory read in progress
mem_wbusy  input  1  memory write in progress
arb_busy  output  1  high whenever state != IDLE
mem_timeout  output  1  pulses together with ready when a transaction aborted on timeout

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-transaction):
  - State goes to IDLE; last_grant goes to DCACHE, so ICACHE wins the first tie.
  - All outputs are 0 and the timeout counter is cleared. No ready pulse is emitted for an aborted transaction.
  - If a request is still held after reset release, it is re-arbitrated from scratch.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - A DCACHE request is dcache_wen | dcache_ren; dcache_wen takes precedence, so an access with both set is a write.
  - Only one requester pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - On grant, latch addr, wdata, wmask, op (read/write) and grantee; update last_grant; go to ISSUE.
  - Nothing pending: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Read: mem_rstrb=1.
  - Write: mem_wmask = latched mask.
  - Next state is WAIT and the timeout counter is cleared.
  - A write with latched wmask=4'b0000 issues no strobe and goes straight to DONE.
- WAIT:
  - mem_addr and mem_wdata hold their latched values; strobes are 0.
  - Each cycle, if mem_rbusy=0 and mem_wbusy=0: capture mem_rdata into the rdata register and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (TIMEOUT != 0): go to DONE with the timeout flag set and rdata=0.
- DONE (exactly 1 cycle):
  - Assert the granted requester's ready. icache_rdata and dcache_rdata both show the captured data.
  - mem_timeout equals the flag. Next state is IDLE.
  - The other requester's ready stays 0.
- Requester contract: the requester must drop its request on the edge where it samples ready=1. A request still high in IDLE is treated as a new transaction.
- Minimum latency, request to ready, with a zero-wait memory: request seen in IDLE at cycle 0; ISSUE at cycle 1; WAIT at cycle 2; ready at cycle 3. Back-to-back transactions are 4 cycles each.
- Requests that change while a transaction is in flight are ignored; only the latched values are used.
- rdata outputs hold their last captured value outside DONE (reset value 0). Write transactions leave rdata unchanged.

Test Plan:
- ICACHE only: icache_addr=0x100, zero-wait memory returning 0xDEADBEEF → mem_rstrb pulses at cycle 1 with mem_addr=0x100; icache_ready=1 at cycle 3 with icache_rdata=0xDEADBEEF; dcache_ready stays 0.
- DCACHE write: addr=0x200, wdata=0x12345678, wmask=4'b0011, wen=1 → mem_wmask=0011 for exactly one cycle; mem_addr/mem_wdata held through DONE; dcache_ready pulses once; mem_rstrb never asserts.
- Simultaneous requests right after reset, both held continuously → grants alternate ICACHE, DCACHE, ICACHE…; each ready arrives 4 cycles after the previous one.
- mem_rbusy held high for 5 cycles after ISSUE → ready delayed exactly 5 cycles beyond minimum; data captured on the first not-busy cycle.
- TIMEOUT=4 with mem_rbusy stuck high → ready and mem_timeout pulse together 4 WAIT cycles after ISSUE with rdata=0; arbiter returns to IDLE and serves the next request.
- reset asserted during WAIT → all outputs 0 asynchronously with no ready pulse; the held request is re-served from IDLE after release. A wen with wmask=0 → dcache_ready at cycle 2 with no memory strobe.

Source files
------------

// File: rtl/mem_arbiter_fsm.sv
// Shares the single main-memory port between ICACHE (read-only) and DCACHE (read/write).
// Round-robin on ties; one transaction at a time through ISSUE/WAIT/DONE with a WAIT timeout.
module mem_arbiter_fsm #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_W    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_req,
  output logic [31:0] icache_rdata,
  output logic        icache_ready,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic [3:0]  dcache_wmask,
  input  logic        dcache_wen,
  input  logic        dcache_ren,
  output logic [31:0] dcache_rdata,
  output logic        dcache_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy,
  output logic        arb_busy,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 32'd0);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_r, state_s;
  logic            last_d_r, last_d_s;   // last grant went to DCACHE
  logic            sel_d_r, sel_d_s;     // current grantee is DCACHE
  logic            op_w_r, op_w_s;
  logic [31:0]     addr_r, addr_s;
  logic [31:0]     wdata_r, wdata_s;
  logic [3:0]      wmask_r, wmask_s;
  logic [31:0]     rdata_r, rdata_s;
  logic [TO_W-1:0] cnt_r, cnt_s;
  logic            to_r, to_s;
  logic            dreq_s, grant_d_s;

  logic            rstrb_r, rstrb_s;
  logic [3:0]      wstrb_r, wstrb_s;
  logic            irdy_r, irdy_s;
  logic            drdy_r, drdy_s;
  logic            busy_r, busy_s;
  logic            tout_r, tout_s;

  assign dreq_s = dcache_wen | dcache_ren;

  // Arbitration, transaction latching and sequencing through ISSUE/WAIT/DONE
  always_comb begin
    state_s   = state_r;
    last_d_s  = last_d_r;
    sel_d_s   = sel_d_r;
    op_w_s    = op_w_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    wmask_s   = wmask_r;
    rdata_s   = rdata_r;
    cnt_s     = cnt_r;
    to_s      = to_r;
    grant_d_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (icache_req || dreq_s) begin
          grant_d_s = dreq_s && (!icache_req || !last_d_r);
          sel_d_s   = grant_d_s;
          last_d_s  = grant_d_s;
          addr_s    = grant_d_s ? dcache_addr  : icache_addr;
          wdata_s   = grant_d_s ? dcache_wdata : 32'd0;
          wmask_s   = grant_d_s ? dcache_wmask : 4'b0000;
          op_w_s    = grant_d_s && dcache_wen;
          to_s      = 1'b0;
          state_s   = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_s = {TO_W{1'b0}};
        // an empty write mask has nothing to send, so skip the memory handshake
        if (op_w_r && (wmask_r == 4'b0000)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_rbusy && !mem_wbusy) begin
          rdata_s = op_w_r ? rdata_r : mem_rdata;
          state_s = S_DONE;
        end else if (TO_EN && ((cnt_r + CNT_ONE) == TO_MAX)) begin
          to_s    = 1'b1;
          rdata_s = 32'd0;
          state_s = S_DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output values for the cycle being entered, so every output leaves straight from a flop
  always_comb begin
    rstrb_s = (state_s == S_ISSUE) && !op_w_s;
    wstrb_s = ((state_s == S_ISSUE) && op_w_s) ? wmask_s : 4'b0000;
    irdy_s  = (state_s == S_DONE) && !sel_d_s;
    drdy_s  = (state_s == S_DONE) && sel_d_s;
    busy_s  = (state_s != S_IDLE);
    tout_s  = (state_s == S_DONE) && to_s;
  end

  // State and latched transaction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      last_d_r <= 1'b1;
      sel_d_r  <= 1'b0;
      op_w_r   <= 1'b0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      wmask_r  <= 4'b0000;
      rdata_r  <= 32'd0;
      cnt_r    <= {TO_W{1'b0}};
      to_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      last_d_r <= last_d_s;
      sel_d_r  <= sel_d_s;
      op_w_r   <= op_w_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      wmask_r  <= wmask_s;
      rdata_r  <= rdata_s;
      cnt_r    <= cnt_s;
      to_r     <= to_s;
    end
  end

  // Registered strobes and handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstrb_r <= 1'b0;
      wstrb_r <= 4'b0000;
      irdy_r  <= 1'b0;
      drdy_r  <= 1'b0;
      busy_r  <= 1'b0;
      tout_r  <= 1'b0;
    end else begin
      rstrb_r <= rstrb_s;
      wstrb_r <= wstrb_s;
      irdy_r  <= irdy_s;
      drdy_r  <= drdy_s;
      busy_r  <= busy_s;
      tout_r  <= tout_s;
    end
  end

  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign mem_wmask    = wstrb_r;
  assign mem_rstrb    = rstrb_r;
  assign icache_rdata = rdata_r;
  assign dcache_rdata = rdata_r;
  assign icache_ready = irdy_r;
  assign dcache_ready = drdy_r;
  assign arb_busy     = busy_r;
  assign mem_timeout  = tout_r;

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Self-checking bench for mem_arbiter_fsm: directed scenarios plus randomized rounds checked
// against a transaction-level timing/arbitration model.
module tb_mem_arbiter_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] icache_addr = 32'd0;
  logic        icache_req = 1'b0;
  logic [31:0] icache_rdata;
  logic        icache_ready;
  logic [31:0] dcache_addr = 32'd0;
  logic [31:0] dcache_wdata = 32'd0;
  logic [3:0]  dcache_wmask = 4'b0000;
  logic        dcache_wen = 1'b0;
  logic        dcache_ren = 1'b0;
  logic [31:0] dcache_rdata;
  logic        dcache_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rbusy = 1'b0;
  logic        mem_wbusy = 1'b0;
  logic        arb_busy;
  logic        mem_timeout;

  // second instance with a short timeout
  logic [31:0] t_icache_addr = 32'd0;
  logic        t_icache_req = 1'b0;
  logic [31:0] t_icache_rdata;
  logic        t_icache_ready;
  logic [31:0] t_dcache_addr = 32'd0;
  logic [31:0] t_dcache_wdata = 32'd0;
  logic [3:0]  t_dcache_wmask = 4'b0000;
  logic        t_dcache_wen = 1'b0;
  logic        t_dcache_ren = 1'b0;
  logic [31:0] t_dcache_rdata;
  logic        t_dcache_ready;
  logic [31:0] t_mem_addr;
  logic [31:0] t_mem_wdata;
  logic [3:0]  t_mem_wmask;
  logic        t_mem_rstrb;
  logic [31:0] t_mem_rdata = 32'd0;
  logic        t_mem_rbusy = 1'b0;
  logic        t_mem_wbusy = 1'b0;
  logic        t_arb_busy;
  logic        t_mem_timeout;

  int          checks = 0;
  int          errors = 0;
  bit          last_grant_d = 1'b1;
  logic [31:0] rdata_exp = 32'd0;

  mem_arbiter_fsm #(.TIMEOUT(8), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .icache_addr(icache_addr), .icache_req(icache_req),
    .icache_rdata(icache_rdata), .icache_ready(icache_ready),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata), .dcache_wmask(dcache_wmask),
    .dcache_wen(dcache_wen), .dcache_ren(dcache_ren),
    .dcache_rdata(dcache_rdata), .dcache_ready(dcache_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy),
    .arb_busy(arb_busy), .mem_timeout(mem_timeout)
  );

  mem_arbiter_fsm #(.TIMEOUT(4), .TO_W(3)) dut_to (
    .clk(clk), .reset(reset),
    .icache_addr(t_icache_addr), .icache_req(t_icache_req),
    .icache_rdata(t_icache_rdata), .icache_ready(t_icache_ready),
    .dcache_addr(t_dcache_addr), .dcache_wdata(t_dcache_wdata), .dcache_wmask(t_dcache_wmask),
    .dcache_wen(t_dcache_wen), .dcache_ren(t_dcache_ren),
    .dcache_rdata(t_dcache_rdata), .dcache_ready(t_dcache_ready),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_wmask(t_mem_wmask), .mem_rstrb(t_mem_rstrb),
    .mem_rdata(t_mem_rdata), .mem_rbusy(t_mem_rbusy), .mem_wbusy(t_mem_wbusy),
    .arb_busy(t_arb_busy), .mem_timeout(t_mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    logic [136:0] all_m, all_t;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    all_m = {mem_addr, mem_wdata, mem_wmask, mem_rstrb, icache_ready, dcache_ready,
             icache_rdata, dcache_rdata, arb_busy, mem_timeout};
    all_t = {t_mem_addr, t_mem_wdata, t_mem_wmask, t_mem_rstrb, t_icache_ready, t_dcache_ready,
             t_icache_rdata, t_dcache_rdata, t_arb_busy, t_mem_timeout};
    checks++;
    if (all_m !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_m); end
    checks++;
    if (all_t !== '0) begin errors++; $display("FAIL reset_outputs_to got %h exp 0", all_t); end
    reset = 1'b0;
    last_grant_d = 1'b1;
    rdata_exp = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", arb_busy); end
  endtask

  // One round: ICACHE and/or DCACHE raise requests together; the model predicts grant order,
  // strobe/ready cycles from the latency rules, and the data each requester must see.
  task automatic run_round(input bit ri, input bit rd, input bit dw, input bit dboth,
                           input logic [3:0] dmask, input int bi, input int bd,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                           input logic [31:0] idat, input logic [31:0] ddat);
    bit two, first_d, e_rstrb, e_irdy, e_drdy, e_busy, act_i, act_d;
    logic [3:0] e_wmask;
    int lat_i, lat_d, rdy_i, rdy_d, iss_i, iss_d, last_t, k;
    two     = ri && rd;
    first_d = two ? !last_grant_d : rd;
    lat_i   = 3 + bi;
    lat_d   = (dw && dmask == 4'b0000) ? 2 : 3 + bd;
    rdy_i   = -10;
    rdy_d   = -10;
    if (first_d) begin
      rdy_d = lat_d;
      if (two) rdy_i = rdy_d + 1 + lat_i;
    end else begin
      rdy_i = lat_i;
      if (two) rdy_d = rdy_i + 1 + lat_d;
    end
    iss_i  = rdy_i - lat_i + 1;
    iss_d  = rdy_d - lat_d + 1;
    last_t = ((rdy_i > rdy_d) ? rdy_i : rdy_d) + 1;

    icache_req   = ri;
    icache_addr  = ia;
    dcache_wen   = rd && dw;
    dcache_ren   = rd && (!dw || dboth);
    dcache_addr  = da;
    dcache_wdata = dwd;
    dcache_wmask = dmask;
    mem_rbusy    = 1'b0;
    mem_wbusy    = 1'b0;
    mem_rdata    = $urandom;
    for (int t = 1; t <= last_t; t++) begin
      @(posedge clk); #1;
      act_i   = ri && t >= iss_i && t <= rdy_i;
      act_d   = rd && t >= iss_d && t <= rdy_d;
      e_rstrb = (ri && t == iss_i) || (rd && !dw && t == iss_d);
      e_wmask = (rd && dw && t == iss_d) ? dmask : 4'b0000;
      e_irdy  = ri && t == rdy_i;
      e_drdy  = rd && t == rdy_d;
      e_busy  = act_i || act_d;
      if (e_irdy) rdata_exp = idat;
      if (e_drdy && !dw) rdata_exp = ddat;
      checks++;
      if (mem_rstrb !== e_rstrb) begin errors++; $display("FAIL rstrb t=%0d got %b exp %b", t, mem_rstrb, e_rstrb); end
      checks++;
      if (mem_wmask !== e_wmask) begin errors++; $display("FAIL wmask t=%0d got %b exp %b", t, mem_wmask, e_wmask); end
      checks++;
      if (icache_ready !== e_irdy) begin errors++; $display("FAIL icache_ready t=%0d got %b exp %b", t, icache_ready, e_irdy); end
      checks++;
      if (dcache_ready !== e_drdy) begin errors++; $display("FAIL dcache_ready t=%0d got %b exp %b", t, dcache_ready, e_drdy); end
      checks++;
      if (arb_busy !== e_busy) begin errors++; $display("FAIL arb_busy t=%0d got %b exp %b", t, arb_busy, e_busy); end
      checks++;
      if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mem_timeout t=%0d got %b exp 0", t, mem_timeout); end
      checks++;
      if (icache_rdata !== rdata_exp || dcache_rdata !== rdata_exp) begin
        errors++; $display("FAIL rdata t=%0d got %h/%h exp %h", t, icache_rdata, dcache_rdata, rdata_exp);
      end
      if (act_i) begin
        checks++;
        if (mem_addr !== ia) begin errors++; $display("FAIL mem_addr_i t=%0d got %h exp %h", t, mem_addr, ia); end
      end
      if (act_d) begin
        checks++;
        if (mem_addr !== da) begin errors++; $display("FAIL mem_addr_d t=%0d got %h exp %h", t, mem_addr, da); end
      end
      if (act_d && dw) begin
        checks++;
        if (mem_wdata !== dwd) begin errors++; $display("FAIL mem_wdata t=%0d got %h exp %h", t, mem_wdata, dwd); end
      end
      // requester and memory responses for the edge closing this cycle
      if (e_irdy) icache_req = 1'b0;
      if (e_drdy) begin dcache_wen = 1'b0; dcache_ren = 1'b0; end
      mem_rbusy = 1'b0;
      mem_wbusy = 1'b0;
      mem_rdata = $urandom;
      if (act_i && !e_irdy) begin
        icache_addr = $urandom;
        k = t - iss_i;
        mem_rbusy = (k >= 1 && k <= bi);
        if (k == bi + 1) mem_rdata = idat;
      end
      if (act_d && !e_drdy) begin
        dcache_addr  = $urandom;
        dcache_wdata = $urandom;
        dcache_wmask = 4'($urandom);
        k = t - iss_d;
        if (dw) mem_wbusy = (k >= 1 && k <= bd);
        else    mem_rbusy = (k >= 1 && k <= bd);
        if (!dw && k == bd + 1) mem_rdata = ddat;
      end
    end
    last_grant_d = two ? !first_d : rd;
  endtask

  task automatic test_icache_read;
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 0,
              32'h0000_0100, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0);
  endtask

  task automatic test_dcache_write;
    run_round(1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 0, 0,
              32'd0, 32'h0000_0200, 32'h1234_5678, 32'd0, 32'd0);
  endtask

  task automatic test_back_to_back;
    int n, p;
    bit e_irdy, e_drdy;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_grant_d = 1'b1;
    rdata_exp = 32'd0;
    icache_req = 1'b1; icache_addr = 32'h0000_0500;
    dcache_ren = 1'b1; dcache_wen = 1'b0; dcache_addr = 32'h0000_0600;
    mem_rbusy = 1'b0; mem_wbusy = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      @(posedge clk); #1;
      n = (t - 1) / 4;
      p = (t - 1) % 4;
      e_irdy = (p == 2) && (n % 2 == 0);
      e_drdy = (p == 2) && (n % 2 == 1);
      if (p == 2) rdata_exp = 32'hA500_0000 | 32'(t - 1);
      checks++;
      if (icache_ready !== e_irdy || dcache_ready !== e_drdy) begin
        errors++; $display("FAIL b2b_ready t=%0d got %b%b exp %b%b", t, icache_ready, dcache_ready, e_irdy, e_drdy);
      end
      checks++;
      if (mem_rstrb !== (p == 0)) begin errors++; $display("FAIL b2b_rstrb t=%0d got %b", t, mem_rstrb); end
      checks++;
      if (arb_busy !== (p != 3)) begin errors++; $display("FAIL b2b_busy t=%0d got %b", t, arb_busy); end
      if (p == 0) begin
        checks++;
        if (mem_addr !== ((n % 2 == 0) ? 32'h0000_0500 : 32'h0000_0600)) begin
          errors++; $display("FAIL b2b_addr t=%0d got %h", t, mem_addr);
        end
      end
      if (p == 2) begin
        checks++;
        if (icache_rdata !== rdata_exp) begin errors++; $display("FAIL b2b_rdata t=%0d got %h exp %h", t, icache_rdata, rdata_exp); end
      end
      if (t == 23) begin icache_req = 1'b0; dcache_ren = 1'b0; end
      mem_rdata = 32'hA500_0000 | 32'(t);
    end
    last_grant_d = 1'b1;
  endtask

  task automatic test_busy_delay;
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 5, 0,
              32'h0000_0700, 32'd0, 32'd0, 32'h600D_CAFE, 32'd0);
  endtask

  task automatic test_zero_mask;
    run_round(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 0, 0,
              32'd0, 32'h0000_0800, 32'hFFFF_0000, 32'd0, 32'd0);
  endtask

  task automatic test_timeout;
    bit pd, pb, e_rdy;
    int rdy;
    logic [31:0] ed;
    for (int p = 0; p < 3; p++) begin
      pd  = (p == 2);
      pb  = (p == 1);
      rdy = pb ? 6 : 3;
      ed  = (p == 0) ? 32'hCAFE_F00D : ((p == 1) ? 32'd0 : 32'h0055_AA11);
      t_icache_req  = !pd;
      t_icache_addr = 32'h0000_0300 + 32'(4 * p);
      t_dcache_ren  = pd;
      t_dcache_addr = 32'h0000_0300 + 32'(4 * p);
      t_mem_rbusy   = pb;
      t_mem_rdata   = pb ? 32'hBADB_AD00 : ed;
      for (int t = 1; t <= rdy + 1; t++) begin
        @(posedge clk); #1;
        e_rdy = (t == rdy);
        checks++;
        if (t_mem_rstrb !== (t == 1)) begin errors++; $display("FAIL to_rstrb p=%0d t=%0d got %b", p, t, t_mem_rstrb); end
        checks++;
        if (t_icache_ready !== (e_rdy && !pd) || t_dcache_ready !== (e_rdy && pd)) begin
          errors++; $display("FAIL to_ready p=%0d t=%0d got %b%b", p, t, t_icache_ready, t_dcache_ready);
        end
        checks++;
        if (t_mem_timeout !== (e_rdy && pb)) begin errors++; $display("FAIL to_flag p=%0d t=%0d got %b", p, t, t_mem_timeout); end
        checks++;
        if (t_arb_busy !== (t <= rdy)) begin errors++; $display("FAIL to_busy p=%0d t=%0d got %b", p, t, t_arb_busy); end
        if (t == 1) begin
          checks++;
          if (t_mem_addr !== t_dcache_addr) begin errors++; $display("FAIL to_addr p=%0d got %h exp %h", p, t_mem_addr, t_dcache_addr); end
        end
        if (e_rdy) begin
          checks++;
          if (t_icache_rdata !== ed || t_dcache_rdata !== ed) begin
            errors++; $display("FAIL to_rdata p=%0d got %h/%h exp %h", p, t_icache_rdata, t_dcache_rdata, ed);
          end
          t_icache_req = 1'b0;
          t_dcache_ren = 1'b0;
          t_mem_rbusy  = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [136:0] all_m;
    bit e_rdy;
    icache_req = 1'b1; icache_addr = 32'h0000_0400;
    dcache_wen = 1'b0; dcache_ren = 1'b0;
    mem_rbusy = 1'b1; mem_wbusy = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (arb_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", arb_busy); end
    #2 reset = 1'b1;
    #1;
    all_m = {mem_addr, mem_wdata, mem_wmask, mem_rstrb, icache_ready, dcache_ready,
             icache_rdata, dcache_rdata, arb_busy, mem_timeout};
    checks++;
    if (all_m !== '0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 0", all_m); end
    last_grant_d = 1'b1;
    rdata_exp = 32'd0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (icache_ready !== 1'b0 || arb_busy !== 1'b0) begin
        errors++; $display("FAIL mid_hold got rdy %b busy %b exp 0", icache_ready, arb_busy);
      end
    end
    reset = 1'b0;
    mem_rbusy = 1'b0;
    mem_rdata = 32'h1357_2468;
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1;
      e_rdy = (t == 3);
      checks++;
      if (mem_rstrb !== (t == 1)) begin errors++; $display("FAIL mid_rstrb t=%0d got %b", t, mem_rstrb); end
      checks++;
      if (icache_ready !== e_rdy) begin errors++; $display("FAIL mid_ready t=%0d got %b exp %b", t, icache_ready, e_rdy); end
      if (e_rdy) begin
        checks++;
        if (icache_rdata !== 32'h1357_2468 || mem_addr !== 32'h0000_0400) begin
          errors++; $display("FAIL mid_reserve got data %h addr %h", icache_rdata, mem_addr);
        end
        icache_req = 1'b0;
      end
    end
    rdata_exp = 32'h1357_2468;
    last_grant_d = 1'b0;
  endtask

  task automatic test_random;
    int sel;
    bit ri, rd, dw, dboth;
    logic [3:0] dmask;
    for (int r = 0; r < 30; r++) begin
      sel   = $urandom_range(1, 3);
      ri    = (sel & 1) != 0;
      rd    = (sel & 2) != 0;
      dw    = $urandom_range(0, 1) == 1;
      dboth = dw && ($urandom_range(0, 1) == 1);
      dmask = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      run_round(ri, rd, dw, dboth, dmask, $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom, $urandom, $urandom, $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_back_to_back();
    test_busy_delay();
    test_zero_mask();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
